// File: rtl/debounce_multi_if.sv
// -----------------------------------------------------------------------------
// debounce_multi_if
// Bundles the per-channel pin inputs and the debounced level/event outputs of
// debounce_multi into one interface.
//   i_in     : raw asynchronous pins, one bit per channel (master -> slave)
//   o_state  : debounced level per channel                 (slave -> master)
//   o_rise   : one-cycle pulse on a committed 0->1 change
//   o_fall   : one-cycle pulse on a committed 1->0 change
//   o_hold   : one-cycle long-press pulse
//   o_repeat : one-cycle auto-repeat pulse
// -----------------------------------------------------------------------------
interface debounce_multi_if #(
    parameter int CHANNELS = 4
);
    logic [CHANNELS-1:0] i_in;
    logic [CHANNELS-1:0] o_state;
    logic [CHANNELS-1:0] o_rise;
    logic [CHANNELS-1:0] o_fall;
    logic [CHANNELS-1:0] o_hold;
    logic [CHANNELS-1:0] o_repeat;

    modport master (
        output i_in,
        input  o_state, o_rise, o_fall, o_hold, o_repeat
    );

    modport slave (
        input  i_in,
        output o_state, o_rise, o_fall, o_hold, o_repeat
    );
endinterface

// File: rtl/debounce_multi.sv
// -----------------------------------------------------------------------------
// debounce_multi
// Multi-channel button/switch debouncer. Each channel synchronises its raw pin,
// accepts a new level only after MAX_COUNT consecutive disagreeing cycles, and
// reports rise/fall pulses plus long-press (hold) and auto-repeat pulses.
// Ports:
//   i_clock : sole clock, rising edge
//   i_reset : synchronous active-high reset
//   bus     : debounce_multi_if.slave (i_in, o_state, o_rise, o_fall,
//             o_hold, o_repeat), all CHANNELS wide, outputs registered
// -----------------------------------------------------------------------------
module debounce_multi #(
    parameter int CHANNELS     = 4,
    parameter int MAX_COUNT    = 16,
    parameter int SYNC_STAGES  = 2,
    parameter int HOLD_COUNT   = 1024,
    parameter int REPEAT_COUNT = 256
) (
    input  logic            i_clock,
    input  logic            i_reset,
    debounce_multi_if.slave bus
);

    localparam int DB_W   = $clog2(MAX_COUNT);
    localparam int HC_MAX = (HOLD_COUNT > REPEAT_COUNT) ? HOLD_COUNT : REPEAT_COUNT;
    localparam int HC_W   = $clog2(HC_MAX + 1);

    localparam logic [DB_W-1:0] DB_LAST   = DB_W'(MAX_COUNT - 1);
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_COUNT - 1);
    localparam logic [HC_W-1:0] REP_LAST  = HC_W'((REPEAT_COUNT == 0) ? 0 : REPEAT_COUNT - 1);

    typedef enum logic [1:0] {
        P_IDLE  = 2'd0,
        P_PRESS = 2'd1,
        P_HELD  = 2'd2
    } press_e;

    logic [CHANNELS-1:0] w_state;
    logic [CHANNELS-1:0] w_rise;
    logic [CHANNELS-1:0] w_fall;
    logic [CHANNELS-1:0] w_hold;
    logic [CHANNELS-1:0] w_repeat;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [SYNC_STAGES-1:0] r_sync;
        logic                   r_state;
        logic [DB_W-1:0]        r_dcnt;
        logic [DB_W-1:0]        w_dcnt_nxt;
        logic                   r_rise;
        logic                   r_fall;
        logic                   r_hold;
        logic                   r_repeat;
        press_e                 r_fsm;
        press_e                 w_fsm_nxt;
        logic [HC_W-1:0]        r_hcnt;
        logic [HC_W-1:0]        w_hcnt_nxt;
        logic                   w_hold_nxt;
        logic                   w_repeat_nxt;
        logic                   w_s;
        logic                   w_commit;
        logic                   w_rise_c;
        logic                   w_fall_c;

        assign w_s      = r_sync[SYNC_STAGES-1];
        // A level change is accepted on the MAX_COUNT-th consecutive mismatch.
        assign w_commit = (w_s != r_state) && (r_dcnt == DB_LAST);
        assign w_rise_c = w_commit & w_s;
        assign w_fall_c = w_commit & ~w_s;

        // Any cycle of agreement (or a commit) restarts the mismatch count.
        always_comb begin
            w_dcnt_nxt = '0;
            if ((w_s != r_state) && (r_dcnt != DB_LAST)) begin
                w_dcnt_nxt = r_dcnt + 1'b1;
            end
        end

        // Press tracking; a fall commit wins over a hold/repeat due that edge.
        always_comb begin
            w_fsm_nxt    = r_fsm;
            w_hcnt_nxt   = r_hcnt;
            w_hold_nxt   = 1'b0;
            w_repeat_nxt = 1'b0;
            unique case (r_fsm)
                P_IDLE: begin
                    if (w_rise_c) begin
                        w_fsm_nxt  = P_PRESS;
                        w_hcnt_nxt = '0;
                    end
                end
                P_PRESS: begin
                    if (w_fall_c) begin
                        w_fsm_nxt  = P_IDLE;
                        w_hcnt_nxt = '0;
                    end else if (r_hcnt == HOLD_LAST) begin
                        w_hold_nxt = 1'b1;
                        w_hcnt_nxt = '0;
                        w_fsm_nxt  = P_HELD;
                    end else begin
                        w_hcnt_nxt = r_hcnt + 1'b1;
                    end
                end
                P_HELD: begin
                    if (w_fall_c) begin
                        w_fsm_nxt  = P_IDLE;
                        w_hcnt_nxt = '0;
                    end else if (REPEAT_COUNT != 0) begin
                        if (r_hcnt == REP_LAST) begin
                            w_repeat_nxt = 1'b1;
                            w_hcnt_nxt   = '0;
                        end else begin
                            w_hcnt_nxt = r_hcnt + 1'b1;
                        end
                    end
                end
                default: begin
                    w_fsm_nxt  = P_IDLE;
                    w_hcnt_nxt = '0;
                end
            endcase
        end

        always_ff @(posedge i_clock) begin
            if (i_reset) begin
                r_sync   <= '0;
                r_state  <= 1'b0;
                r_dcnt   <= '0;
                r_rise   <= 1'b0;
                r_fall   <= 1'b0;
                r_hold   <= 1'b0;
                r_repeat <= 1'b0;
                r_fsm    <= P_IDLE;
                r_hcnt   <= '0;
            end else begin
                r_sync   <= {r_sync[SYNC_STAGES-2:0], bus.i_in[g]};
                r_dcnt   <= w_dcnt_nxt;
                if (w_commit) begin
                    r_state <= w_s;
                end
                r_rise   <= w_rise_c;
                r_fall   <= w_fall_c;
                r_hold   <= w_hold_nxt;
                r_repeat <= w_repeat_nxt;
                r_fsm    <= w_fsm_nxt;
                r_hcnt   <= w_hcnt_nxt;
            end
        end

        assign w_state[g]  = r_state;
        assign w_rise[g]   = r_rise;
        assign w_fall[g]   = r_fall;
        assign w_hold[g]   = r_hold;
        assign w_repeat[g] = r_repeat;
    end

    assign bus.o_state  = w_state;
    assign bus.o_rise   = w_rise;
    assign bus.o_fall   = w_fall;
    assign bus.o_hold   = w_hold;
    assign bus.o_repeat = w_repeat;

endmodule

// File: tb/tb_debounce_multi.sv
// -----------------------------------------------------------------------------
// tb_debounce_multi
// Self-checking bench for debounce_multi (CHANNELS=4, SYNC=2, MAX=4, HOLD=10,
// REPEAT=3). A reference model derives outputs from the recorded pin history:
// a level commits when the last MAX synchronised samples all disagree with the
// current level and no commit/reset happened within those samples; hold and
// repeat pulses are derived from the elapsed edges since rise/hold.
// -----------------------------------------------------------------------------
module tb_debounce_multi;
    localparam int CH   = 4;
    localparam int SYNC = 2;
    localparam int MAX  = 4;
    localparam int HOLD = 10;
    localparam int REP  = 3;
    localparam int NMAX = 4096;

    logic clk = 1'b0;
    logic rst = 1'b1;

    debounce_multi_if #(.CHANNELS(CH)) bus ();

    debounce_multi #(
        .CHANNELS     (CH),
        .MAX_COUNT    (MAX),
        .SYNC_STAGES  (SYNC),
        .HOLD_COUNT   (HOLD),
        .REPEAT_COUNT (REP)
    ) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [CH-1:0] in_h  [NMAX];
    bit            rst_h [NMAX];
    int            n = 0;
    logic [CH-1:0] m_state = '0;
    logic [CH-1:0] e_rise  = '0;
    logic [CH-1:0] e_fall  = '0;
    logic [CH-1:0] e_hold  = '0;
    logic [CH-1:0] e_rep   = '0;
    int            last_ev [CH];
    int            rise_t  [CH];
    int            hold_t  [CH];

    // Synchronised sample seen by the debouncer at edge m.
    function automatic logic s_at(input int m, input int ch);
        if (m - SYNC < 1) return 1'b0;
        for (int j = m - SYNC; j < m; j++) begin
            if (rst_h[j]) return 1'b0;
        end
        return in_h[m - SYNC][ch];
    endfunction

    task automatic model_edge(input logic [CH-1:0] v, input logic r);
        n++;
        if (n >= NMAX) begin
            $display("FAIL history_overflow got=%0d want<%0d", n, NMAX);
            $fatal(1, "history overflow");
        end
        in_h[n]  = v;
        rst_h[n] = r;
        e_rise = '0; e_fall = '0; e_hold = '0; e_rep = '0;
        if (r) begin
            m_state = '0;
            for (int c = 0; c < CH; c++) begin
                last_ev[c] = n; rise_t[c] = -1; hold_t[c] = -1;
            end
        end else begin
            for (int c = 0; c < CH; c++) begin
                logic sv;
                bit   commit;
                sv     = s_at(n, c);
                commit = (n - last_ev[c] >= MAX);
                for (int k = 0; k < MAX; k++) begin
                    if (s_at(n - k, c) == m_state[c]) commit = 1'b0;
                end
                if (commit) begin
                    last_ev[c] = n;
                    m_state[c] = sv;
                    if (sv) begin
                        e_rise[c] = 1'b1; rise_t[c] = n; hold_t[c] = -1;
                    end else begin
                        e_fall[c] = 1'b1; rise_t[c] = -1; hold_t[c] = -1;
                    end
                end else if (rise_t[c] >= 0 && hold_t[c] < 0 && n - rise_t[c] == HOLD) begin
                    e_hold[c] = 1'b1; hold_t[c] = n;
                end else if (hold_t[c] >= 0 && REP > 0 && ((n - hold_t[c]) % REP) == 0) begin
                    e_rep[c] = 1'b1;
                end
            end
        end
    endtask

    // Drive inputs mid-cycle, advance one edge, settle, update the model.
    task automatic tick(input logic [CH-1:0] v, input logic r);
        @(negedge clk);
        bus.i_in = v;
        rst      = r;
        @(posedge clk);
        model_edge(v, r);
        #1;
    endtask

    function automatic logic [5*CH-1:0] got();
        return {bus.o_state, bus.o_rise, bus.o_fall, bus.o_hold, bus.o_repeat};
    endfunction

    function automatic logic [5*CH-1:0] expv();
        return {m_state, e_rise, e_fall, e_hold, e_rep};
    endfunction

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tick(4'hF, 1'b1);
            checks++;
            if (got() !== 20'h0) begin
                failures++;
                $display("FAIL reset_outputs cyc=%0d got=%h want=%h", i, got(), 20'h0);
            end
        end
        for (int i = 0; i < 7; i++) begin
            tick(4'hF, 1'b0);
            checks++;
            if (got() !== expv()) begin
                failures++;
                $display("FAIL reset_model cyc=%0d got=%h want=%h", i, got(), expv());
            end
            if (i == 4) begin
                checks++;
                if (bus.o_state !== 4'h0 || bus.o_rise !== 4'h0) begin
                    failures++;
                    $display("FAIL reset_early_rise got state=%h rise=%h want 0/0", bus.o_state, bus.o_rise);
                end
            end
            if (i == 5) begin
                checks++;
                if (bus.o_state !== 4'hF || bus.o_rise !== 4'hF) begin
                    failures++;
                    $display("FAIL reset_release_rise got state=%h rise=%h want F/F", bus.o_state, bus.o_rise);
                end
            end
            if (i == 6) begin
                checks++;
                if (bus.o_state !== 4'hF || bus.o_rise !== 4'h0) begin
                    failures++;
                    $display("FAIL reset_rise_width got state=%h rise=%h want F/0", bus.o_state, bus.o_rise);
                end
            end
        end
    endtask

    task automatic test_glitch();
        logic [13:0] pat;
        for (int i = 0; i < 12; i++) begin
            tick(4'h0, 1'b0);
            checks++;
            if (got() !== expv()) begin
                failures++;
                $display("FAIL glitch_settle cyc=%0d got=%h want=%h", i, got(), expv());
            end
        end
        pat = 14'b00000001110111;  // LSB first: 3 high, 1 low, 3 high, then low
        for (int i = 0; i < 14; i++) begin
            tick({3'b000, pat[i]}, 1'b0);
            checks++;
            if (bus.o_state[0] !== 1'b0 || bus.o_rise[0] !== 1'b0 || got() !== expv()) begin
                failures++;
                $display("FAIL glitch_reject cyc=%0d got=%h want=%h", i, got(), expv());
            end
        end
    endtask

    task automatic test_press_release();
        for (int j = 0; j < 40; j++) begin
            tick((j < 30) ? 4'b0001 : 4'b0000, 1'b0);
            checks++;
            if (got() !== expv()) begin
                failures++;
                $display("FAIL press_model j=%0d got=%h want=%h", j, got(), expv());
            end
            if (j == 5) begin
                checks++;
                if (bus.o_rise !== 4'b0001 || bus.o_state !== 4'b0001) begin
                    failures++;
                    $display("FAIL press_rise got rise=%h state=%h want 1/1", bus.o_rise, bus.o_state);
                end
            end
            if (j == 35) begin
                checks++;
                if (bus.o_fall !== 4'b0001 || bus.o_state !== 4'b0000) begin
                    failures++;
                    $display("FAIL release_fall got fall=%h state=%h want 1/0", bus.o_fall, bus.o_state);
                end
            end
        end
    endtask

    task automatic test_long_press();
        for (int j = 0; j < 32; j++) begin
            int k;
            logic [3:0] want;
            tick((j < 20) ? 4'b0010 : 4'b0000, 1'b0);
            checks++;
            if (got() !== expv()) begin
                failures++;
                $display("FAIL long_model j=%0d got=%h want=%h", j, got(), expv());
            end
            k = j - 5;
            if (k >= 0) begin
                want = {k == 0, k == 10, (k == 13 || k == 16 || k == 19), k == 20};
                checks++;
                if ({bus.o_rise[1], bus.o_hold[1], bus.o_repeat[1], bus.o_fall[1]} !== want) begin
                    failures++;
                    $display("FAIL long_press k=%0d got rise/hold/rep/fall=%b want=%b", k,
                             {bus.o_rise[1], bus.o_hold[1], bus.o_repeat[1], bus.o_fall[1]}, want);
                end
            end
        end
    endtask

    task automatic test_simultaneous();
        for (int j = 0; j < 26; j++) begin
            logic [3:0] v;
            v = (j < 8) ? 4'b1000 : ((j < 16) ? 4'b0100 : 4'b0000);
            tick(v, 1'b0);
            checks++;
            if (got() !== expv()) begin
                failures++;
                $display("FAIL simul_model j=%0d got=%h want=%h", j, got(), expv());
            end
            if (j == 13) begin
                checks++;
                if (bus.o_rise !== 4'b0100 || bus.o_fall !== 4'b1000) begin
                    failures++;
                    $display("FAIL simul_edges got rise=%b fall=%b want 0100/1000", bus.o_rise, bus.o_fall);
                end
            end
        end
    endtask

    task automatic test_reset_mid_press();
        for (int j = 0; j < 20; j++) begin
            tick(4'b0010, 1'b0);
            checks++;
            if (got() !== expv()) begin
                failures++;
                $display("FAIL midrst_pre j=%0d got=%h want=%h", j, got(), expv());
            end
        end
        tick(4'b0010, 1'b1);
        checks++;
        if (got() !== 20'h0) begin
            failures++;
            $display("FAIL midrst_clear got=%h want=%h", got(), 20'h0);
        end
        for (int j = 0; j < 30; j++) begin
            tick((j < 20) ? 4'b0010 : 4'b0000, 1'b0);
            checks++;
            if (got() !== expv()) begin
                failures++;
                $display("FAIL midrst_model j=%0d got=%h want=%h", j, got(), expv());
            end
            if (j == 5 || j == 15) begin
                checks++;
                if (bus.o_rise[1] !== (j == 5) || bus.o_hold[1] !== (j == 15)) begin
                    failures++;
                    $display("FAIL midrst_rehold j=%0d got rise=%b hold=%b want %b/%b", j,
                             bus.o_rise[1], bus.o_hold[1], j == 5, j == 15);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [CH-1:0] cur;
        int bad;
        cur = '0;
        bad = 0;
        for (int j = 0; j < 1500; j++) begin
            logic r;
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(23, 0) == 0) cur[c] = ~cur[c];
            end
            r = ($urandom_range(399, 0) == 0);
            tick(cur, r);
            checks++;
            if (got() !== expv()) begin
                failures++;
                bad++;
                if (bad <= 10)
                    $display("FAIL random_model j=%0d got=%h want=%h", j, got(), expv());
            end
        end
    endtask

    initial begin
        bus.i_in = '0;
        rst      = 1'b1;
        for (int c = 0; c < CH; c++) begin
            last_ev[c] = 0; rise_t[c] = -1; hold_t[c] = -1;
        end
        test_reset();
        test_glitch();
        test_press_release();
        test_long_press();
        test_simultaneous();
        test_reset_mid_press();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/debounce_multi.md
# debounce_multi

Multi-channel debouncer with edge, long-press and auto-repeat events, built to replace single-input debouncers on button/switch inputs. Each channel takes a raw asynchronous pin, synchronises it, and filters it to a stable level. It emits single-cycle rise/fall pulses and, while a channel stays pressed, a hold pulse followed by periodic repeat pulses. Downstream control logic (LED modes, menu stepping) consumes only these pulses and levels.

## Interface
- `CHANNELS`, 4: number of independent input channels (≥1).
- `MAX_COUNT`, 16: consecutive mismatching cycles required to accept a level change (≥2).
- `SYNC_STAGES`, 2: synchroniser flip-flop depth (≥2).
- `HOLD_COUNT`, 1024: cycles from the rise pulse to the hold pulse (≥2).
- `REPEAT_COUNT`, 256: period of repeat pulses after hold; 0 disables repeat.

- `clock`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in`  in  CHANNELS  raw asynchronous inputs, one bit per channel.
- `state`  out  CHANNELS  debounced level per channel.
- `rise`  out  CHANNELS  one-cycle pulse when `state` bit commits 0→1.
- `fall`  out  CHANNELS  one-cycle pulse when `state` bit commits 1→0.
- `hold`  out  CHANNELS  one-cycle long-press pulse.
- `repeat`  out  CHANNELS  one-cycle auto-repeat pulse.

## Operation
- All channels are fully independent; per-channel logic is replicated by generate.
- Synchroniser: `in[i]` passes through SYNC_STAGES flops; `s` is the last stage.
- Debounce counter, width $clog2(MAX_COUNT):
  - `s == state`: counter ← 0.
  - `s != state` and counter < MAX_COUNT-1: counter ← counter+1.
  - `s != state` and counter == MAX_COUNT-1: commit. `state` ← `s`, counter ← 0, and `rise` or `fall` asserts for that cycle.
- A single cycle of agreement (glitch) restarts the count from 0.
- Press FSM per channel, with hold/repeat counter width $clog2(max(HOLD_COUNT,REPEAT_COUNT)+1):
  - IDLE: `state`=0. On rise commit: → PRESS, counter ← 0.
  - PRESS: counter increments each cycle. When counter == HOLD_COUNT-1: `hold` pulses, counter ← 0, → HELD.
  - HELD: if REPEAT_COUNT == 0, stay with no pulses. Otherwise counter increments; at REPEAT_COUNT-1, `repeat` pulses and counter ← 0.
  - Fall commit from PRESS or HELD: → IDLE, counter ← 0. Any hold/repeat pulse due on that same edge is suppressed.
- Outputs are registered; no combinational path from `in` to any output.

## Timing
- Reset: while `reset` is high at an edge, all synchroniser flops, `state`, counters and all pulse outputs become 0, and the FSM goes to IDLE.
- No pulse asserts in any cycle following a reset edge.
- Latency: let edge e0 be the first edge to sample a new stable level into stage 1. `state` and `rise`/`fall` update at edge e0+SYNC_STAGES+MAX_COUNT-1. With SYNC=2 and MAX=4, that is e0+5.
- Hold: `hold` asserts exactly HOLD_COUNT cycles after the `rise` cycle.
- Repeat: first `repeat` is REPEAT_COUNT cycles after `hold`, then every REPEAT_COUNT cycles.
- Each pulse is high for exactly one cycle per event. `rise` and `hold` never coincide on one channel.
- Different channels may pulse in the same cycle; bits are independent.
- Reset mid-press: everything clears. If the pin is still high after reset release, the channel re-debounces and produces a fresh `rise` at the normal latency.

## Test plan
Parameters for all scenarios: CHANNELS=4, SYNC_STAGES=2, MAX_COUNT=4, HOLD_COUNT=10, REPEAT_COUNT=3.

1. Reset with `in`=4'hF held high for 3 edges, then released at edge R. All outputs are 0 during reset. Then `state`=4'hF and `rise`=4'hF for one cycle at R+5.
2. Glitch rejection: ch0 high for 3 cycles, low for 1, high for 3, then low. `state[0]` stays 0 and no `rise` occurs.
3. Clean press/release on ch0 with e0 at edge 10: `rise[0]` at edge 15. Release sampled at edge 40: `fall[0]` at edge 45, `state[0]`=0 afterwards.
4. Long press on ch1 with `rise[1]` at T: `hold[1]` at T+10, `repeat[1]` at T+13, T+16, T+19. Release committed at T+20: `fall[1]` at T+20, no further `repeat`.
5. Simultaneous events: ch2 press and ch3 release aligned to commit on the same edge. `rise`=4'b0100 and `fall`=4'b1000 in the same cycle.
6. Reset asserted for one edge while ch1 is in HELD with its pin still high: all outputs are 0 the next cycle. `rise[1]` reappears 5 edges after reset release, and `hold[1]` follows 10 cycles after that.
